// File: rtl/pa_fpu.sv
// Shared FPU types: multiplier sequencer states and result flag bundle.
// Used by the sequential multiplier and the FPU main controller.
package pa_fpu;

    typedef enum logic [2:0] {
        FMUL_IDLE,
        FMUL_START,
        FMUL_PADD,
        FMUL_PSHIFT,
        FMUL_RSET,
        FMUL_END,
        FMUL_RVALID
    } e_fmul_state;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic unf;
    } s_fpu_flags;

endpackage

// File: rtl/fpu_mul_normalize.sv
// Product normalisation, truncation, overflow/underflow clamping
// and zero detection for the sequential FP multiplier.
module fpu_mul_normalize
    import pa_fpu::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [2*(MAN_W+1)-1:0] prod_i,
    input  logic signed [EXP_W+1:0] exp_i,
    input  logic                    sign_i,
    input  logic                    zero_i,
    output logic [EXP_W+MAN_W:0]    res_o,
    output s_fpu_flags              flags_o
);

    localparam int PW = 2 * (MAN_W + 1);
    localparam logic signed [EXP_W+1:0] EMAX =
        (EXP_W+2)'((2 ** EXP_W) - 1);

    logic signed [EXP_W+1:0] exp_fin;
    logic [MAN_W-1:0]        frac;
    logic [EXP_W-1:0]        exp_out;
    logic [MAN_W-1:0]        frac_out;

    always_comb begin
        // Product of two [1,2) mantissas lies in [1,4)
        frac = prod_i[PW-1] ? prod_i[PW-2 -: MAN_W]
                            : prod_i[PW-3 -: MAN_W];
        exp_fin = exp_i
                + $signed({{(EXP_W+1){1'b0}}, prod_i[PW-1]});
        exp_out  = exp_fin[EXP_W-1:0];
        frac_out = frac;
        flags_o  = '0;
        if (zero_i) begin
            exp_out  = '0;
            frac_out = '0;
        end else if (exp_fin >= EMAX) begin
            exp_out     = '1;
            frac_out    = '0;
            flags_o.ovf = 1'b1;
        end else if (exp_fin <= 0) begin
            exp_out     = '0;
            frac_out    = '0;
            flags_o.unf = 1'b1;
        end
        flags_o.zero = (exp_out == '0) && (frac_out == '0);
        res_o = {sign_i, exp_out, frac_out};
    end

endmodule

// File: rtl/fpu_mul_seq.sv
// Sequential shift-and-add floating-point multiplier for any
// IEEE-like format, with start / result_valid / ack handshake.
module fpu_mul_seq
    import pa_fpu::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 2 ** (EXP_W - 1) - 1
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] operand_a,
    input  logic [EXP_W+MAN_W:0] operand_b,
    input  logic                 ack,
    output logic                 busy,
    output logic                 result_valid,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 flag_zero,
    output logic                 flag_ovf,
    output logic                 flag_unf
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;
    localparam int PW = 2 * N;
    localparam int CW = $clog2(N + 1);
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);

    e_fmul_state state_q, state_d;

    logic [W-1:0]            opa_q, opb_q;
    logic                    sign_q;
    logic signed [EXP_W+1:0] exp_q;
    logic                    zero_q;
    logic [N-1:0]            mcand_q;
    logic [PW-1:0]           prod_q;
    logic                    carry_q;
    logic [CW-1:0]           cnt_q;
    logic [W-1:0]            res_q;
    s_fpu_flags              flags_q;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             op_zero;
    logic [W-1:0]     n_res;
    s_fpu_flags       n_flags;

    assign ea      = opa_q[W-2 -: EXP_W];
    assign eb      = opb_q[W-2 -: EXP_W];
    assign fa      = opa_q[MAN_W-1:0];
    assign fb      = opb_q[MAN_W-1:0];
    assign op_zero = (ea == '0) || (eb == '0);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state_q <= FMUL_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FMUL_IDLE:   if (start) state_d = FMUL_START;
            FMUL_START:  state_d = op_zero ? FMUL_RSET : FMUL_PADD;
            FMUL_PADD:   state_d = FMUL_PSHIFT;
            FMUL_PSHIFT: state_d = (cnt_q == CW'(1)) ? FMUL_RSET
                                                     : FMUL_PADD;
            FMUL_RSET:   state_d = FMUL_END;
            FMUL_END:    state_d = FMUL_RVALID;
            FMUL_RVALID: if (ack) state_d = FMUL_IDLE;
            default:     state_d = FMUL_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != FMUL_IDLE);
        result_valid = (state_q == FMUL_RVALID);
        result       = res_q;
        flag_zero    = flags_q.zero;
        flag_ovf     = flags_q.ovf;
        flag_unf     = flags_q.unf;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            unique case (state_q)
                FMUL_IDLE: begin
                    if (start) begin
                        opa_q <= operand_a;
                        opb_q <= operand_b;
                    end
                end
                FMUL_START: begin
                    sign_q  <= opa_q[W-1] ^ opb_q[W-1];
                    exp_q   <= $signed({2'b00, ea})
                             + $signed({2'b00, eb}) - BIAS_S;
                    zero_q  <= op_zero;
                    mcand_q <= {1'b1, fa};
                    prod_q  <= {{N{1'b0}}, 1'b1, fb};
                    carry_q <= 1'b0;
                    cnt_q   <= CW'(N);
                end
                FMUL_PADD: begin
                    if (prod_q[0])
                        {carry_q, prod_q[PW-1:N]} <=
                            {1'b0, prod_q[PW-1:N]} + {1'b0, mcand_q};
                end
                FMUL_PSHIFT: begin
                    prod_q  <= {carry_q, prod_q[PW-1:1]};
                    carry_q <= 1'b0;
                    cnt_q   <= cnt_q - CW'(1);
                end
                FMUL_END: begin
                    res_q   <= n_res;
                    flags_q <= n_flags;
                end
                default: ;
            endcase
        end
    end

    fpu_mul_normalize #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm (
        .prod_i  (prod_q),
        .exp_i   (exp_q),
        .sign_i  (sign_q),
        .zero_i  (zero_q),
        .res_o   (n_res),
        .flags_o (n_flags)
    );

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Directed-vector bench for fpu_mul_seq: default single-precision
// build plus a 5/10-bit half-like build.
module tb_fpu_mul_seq;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    logic        start, ack;
    logic [31:0] opa, opb, res;
    logic        busy, rv, fz, fo, fu;

    logic        s_start, s_ack;
    logic [15:0] s_a, s_b, s_res;
    logic        s_busy, s_rv, s_fz, s_fo, s_fu;

    int n_chk = 0;
    int n_fail = 0;
    int lat;

    fpu_mul_seq dut (
        .clk          (clk),
        .arst         (arst),
        .start        (start),
        .operand_a    (opa),
        .operand_b    (opb),
        .ack          (ack),
        .busy         (busy),
        .result_valid (rv),
        .result       (res),
        .flag_zero    (fz),
        .flag_ovf     (fo),
        .flag_unf     (fu)
    );

    fpu_mul_seq #(
        .EXP_W (5),
        .MAN_W (10)
    ) dut_s (
        .clk          (clk),
        .arst         (arst),
        .start        (s_start),
        .operand_a    (s_a),
        .operand_b    (s_b),
        .ack          (s_ack),
        .busy         (s_busy),
        .result_valid (s_rv),
        .result       (s_res),
        .flag_zero    (s_fz),
        .flag_ovf     (s_fo),
        .flag_unf     (s_fu)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        opa   = a;
        opb   = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        while (!rv && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic mul(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er,
                       input logic [2:0] ef, input int el);
        int n;
        go(a, b);
        wait_rv(n);
        chk({tag, "_lat"}, n, el);
        chk({tag, "_res"}, res, er);
        chk({tag, "_flags"}, {fz, fo, fu}, ef);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_rv", rv, 0);
        chk("ack_busy", busy, 0);
    endtask

    initial begin
        start = 0; ack = 0; opa = 0; opb = 0;
        s_start = 0; s_ack = 0; s_a = 0; s_b = 0;
        #2 arst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rv", rv, 0);
        chk("rst_res", res, 0);
        chk("rst_flags", {fz, fo, fu}, 0);
        chk("rst_s_res", s_res, 0);
        repeat (3) tick();
        arst = 1'b1;

        mul("m15x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 51);
        do_ack();
        mul("mneg", 32'hC0200000, 32'h40800000, 32'hC1200000, 3'b000, 51);
        do_ack();
        mul("zpos", 32'h00000000, 32'h42F60000, 32'h00000000, 3'b100, 3);
        do_ack();
        mul("zneg", 32'h80000000, 32'h42F60000, 32'h80000000, 3'b100, 3);
        do_ack();
        mul("ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 51);
        do_ack();
        mul("unf", 32'h00800000, 32'h00800000, 32'h00000000, 3'b101, 51);
        do_ack();

        mul("hold", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 51);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_rv", rv, 1);
            chk("hold_res", res, 32'h40400000);
        end
        do_ack();

        go(32'h3FC00000, 32'h40000000);
        repeat (5) tick();
        chk("busy_mid", busy, 1);
        start = 1'b1;
        opa = 32'h7F000000;
        opb = 32'h7F000000;
        tick();
        start = 1'b0;
        wait_rv(lat);
        chk("ign_lat", lat + 6, 51);
        chk("ign_res", res, 32'h40400000);
        chk("ign_flags", {fz, fo, fu}, 3'b000);

        ack = 1'b1;
        start = 1'b1;
        opa = 32'h0;
        opb = 32'h0;
        tick();
        ack = 1'b0;
        start = 1'b0;
        chk("as_rv", rv, 0);
        chk("as_busy", busy, 0);
        repeat (5) tick();
        chk("as_busy2", busy, 0);
        chk("as_rv2", rv, 0);
        chk("as_keep", res, 32'h40400000);

        go(32'hC0200000, 32'h40800000);
        repeat (19) tick();
        chk("mr_busy", busy, 1);
        arst = 1'b0;
        #1;
        chk("mr_busy0", busy, 0);
        chk("mr_rv0", rv, 0);
        chk("mr_res0", res, 0);
        chk("mr_flags0", {fz, fo, fu}, 0);
        tick();
        tick();
        arst = 1'b1;
        mul("post", 32'hC0200000, 32'h40800000, 32'hC1200000, 3'b000, 51);
        do_ack();

        s_start = 1'b1;
        s_a = 16'h3E00;
        s_b = 16'h4000;
        tick();
        s_start = 1'b0;
        lat = 0;
        while (!s_rv && lat < 200) begin
            tick();
            lat++;
        end
        chk("s_lat", lat, 25);
        chk("s_res", s_res, 16'h4200);
        chk("s_flags", {s_fz, s_fo, s_fu}, 3'b000);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        chk("s_ack_rv", s_rv, 0);
        chk("s_ack_busy", s_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
